// File: rtl/bt_command_decoder.sv
// bt_command_decoder: receives UART bytes from the Bluetooth module, decodes
// single-character drive commands into the motor command word, and stops the
// motors when the link goes quiet.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | line idle, waiting for a falling edge (start bit)
// START  | half-bit wait, then confirm the start bit (rejects glitches)
// DATA   | sampling 8 data bits once per bit period, LSB first
// STOP   | sample stop bit; on a framing error hold here until rx is high
module bt_command_decoder #(
  parameter int CLK_FREQ       = 100_000_000,
  parameter int BAUD           = 9600,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int DEFAULT_SPEED  = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [15:0] command,
  output logic        cmd_valid,
  output logic        frame_err,
  output logic        link_timeout
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int BW = $clog2(CLKS_PER_BIT + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BW-1:0] HALF_LD = BW'(CLKS_PER_BIT / 2);
  localparam logic [BW-1:0] FULL_LD = BW'(CLKS_PER_BIT - 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    SPD     = 4'(DEFAULT_SPEED);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rx_sync_q;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          stop_hold_q, stop_hold_d;
  logic          byte_valid_q, byte_valid_d;
  logic          frame_err_q, frame_err_d;
  logic [15:0]   cmd_q, cmd_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          link_q, link_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          is_motion, is_digit, recog;
  logic [7:0]    motion_pat;

  // Two-flop synchronizer for the asynchronous serial line (idles high).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // UART receiver state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      stop_hold_q  <= 1'b0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      stop_hold_q  <= stop_hold_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Receiver next state; the bit timer counts down to zero and is reloaded
  // at each sample point.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    stop_hold_d  = stop_hold_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        stop_hold_d = 1'b0;
        if (!rx_sync_q) begin
          state_d   = START;
          bit_cnt_d = HALF_LD;
        end
      end
      START: begin
        if (bit_cnt_q == '0) begin
          if (!rx_sync_q) begin
            state_d   = DATA;
            bit_cnt_d = FULL_LD;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (bit_cnt_q == '0) begin
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_cnt_d = FULL_LD;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (stop_hold_q) begin
          if (rx_sync_q) begin
            state_d     = IDLE;
            stop_hold_d = 1'b0;
          end
        end else if (bit_cnt_q == '0) begin
          if (rx_sync_q) begin
            byte_valid_d = 1'b1;
            state_d      = IDLE;
          end else begin
            frame_err_d = 1'b1;
            stop_hold_d = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Character decode of the byte held in the shift register.
  always_comb begin
    is_motion  = 1'b1;
    motion_pat = 8'h00;
    case (shift_q)
      8'h46, 8'h66: motion_pat = 8'hFF;
      8'h42, 8'h62: motion_pat = 8'hAA;
      8'h4C, 8'h6C: motion_pat = 8'hBB;
      8'h52, 8'h72: motion_pat = 8'hEE;
      8'h53, 8'h73: motion_pat = 8'h00;
      default:      is_motion  = 1'b0;
    endcase
    is_digit = (shift_q >= 8'h30) && (shift_q <= 8'h39);
    recog    = byte_valid_q && (is_motion || is_digit);
  end

  // Command word, watchdog and link-timeout registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q       <= {8'h00, SPD, SPD};
      cmd_valid_q <= 1'b0;
      link_q      <= 1'b0;
      wd_q        <= '0;
    end else begin
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      link_q      <= link_d;
      wd_q        <= wd_d;
    end
  end

  // A recognised byte always wins over a watchdog expiry in the same cycle.
  always_comb begin
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    link_d      = link_q;
    wd_d        = (wd_q == WD_LAST) ? wd_q : wd_q + 1'b1;
    if (recog) begin
      wd_d        = '0;
      link_d      = 1'b0;
      cmd_valid_d = 1'b1;
      if (is_motion) cmd_d[15:8] = motion_pat;
      else           cmd_d[7:0]  = {shift_q[3:0], shift_q[3:0]};
    end else if (wd_q == WD_LAST && !link_q) begin
      cmd_d[15:8] = 8'h00;
      link_d      = 1'b1;
      cmd_valid_d = 1'b1;
    end
  end

  assign command      = cmd_q;
  assign cmd_valid    = cmd_valid_q;
  assign frame_err    = frame_err_q;
  assign link_timeout = link_q;

endmodule

// File: tb/tb_bt_command_decoder.sv
// Directed bench for bt_command_decoder at 10 clocks per UART bit.
module tb_bt_command_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [15:0] command;
  logic        cmd_valid, frame_err, link_timeout;

  int checks = 0;
  int errors = 0;
  int cv_cnt = 0;
  int fe_cnt = 0;
  int cv_base, fe_base;

  bt_command_decoder #(
    .CLK_FREQ(1_000_000), .BAUD(100_000), .TIMEOUT_CYCLES(2000), .DEFAULT_SPEED(5)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .command(command), .cmd_valid(cmd_valid),
    .frame_err(frame_err), .link_timeout(link_timeout)
  );

  always #5 clk = ~clk;

  // Count output pulses away from the active edge.
  always @(negedge clk) begin
    if (cmd_valid) cv_cnt++;
    if (frame_err) fe_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic mark();
    cv_base = cv_cnt;
    fe_base = fe_cnt;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(posedge clk) rx = 1'b0;
    repeat (10) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (10) @(posedge clk);
    end
    rx = stop_bit;
    repeat (10) @(posedge clk);
    rx = 1'b1;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("cmd_in_reset", command, 16'h0055);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("cmd_reset", command, 16'h0055);
    chk("cv_reset", cmd_valid, 1'b0);
    chk("fe_reset", frame_err, 1'b0);
    chk("lt_reset", link_timeout, 1'b0);

    mark();
    send_byte(8'h46, 1'b1);
    chk("cmd_F", command, 16'hFF55);
    chk("cv_F", cv_cnt - cv_base, 1);

    send_byte(8'h38, 1'b1);
    chk("cmd_8", command, 16'hFF88);
    send_byte(8'h6C, 1'b1);
    chk("cmd_l", command, 16'hBB88);

    mark();
    send_byte(8'h52, 1'b0);
    chk("fe_cnt_bad_stop", fe_cnt - fe_base, 1);
    chk("cv_bad_stop", cv_cnt - cv_base, 0);
    chk("cmd_bad_stop", command, 16'hBB88);

    mark();
    send_byte(8'h53, 1'b1);
    chk("cmd_S", command, 16'h0088);
    chk("cv_S", cv_cnt - cv_base, 1);

    mark();
    @(posedge clk) rx = 1'b0;
    repeat (3) @(posedge clk);
    rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("cmd_glitch", command, 16'h0088);
    chk("fe_glitch", fe_cnt - fe_base, 0);
    chk("cv_glitch", cv_cnt - cv_base, 0);

    mark();
    send_byte(8'h73, 1'b1);
    chk("cmd_s_repeat", command, 16'h0088);
    chk("cv_s_repeat", cv_cnt - cv_base, 1);

    do_reset();
    send_byte(8'h46, 1'b1);
    chk("cmd_F2", command, 16'hFF55);
    mark();
    repeat (1900) @(posedge clk);
    #1;
    chk("lt_before_expiry", link_timeout, 1'b0);
    chk("cmd_before_expiry", command, 16'hFF55);
    repeat (200) @(posedge clk);
    #1;
    chk("lt_expired", link_timeout, 1'b1);
    chk("cmd_expired", command, 16'h0055);
    chk("cv_expired", cv_cnt - cv_base, 1);

    mark();
    send_byte(8'h58, 1'b1);
    chk("cmd_X", command, 16'h0055);
    chk("lt_X", link_timeout, 1'b1);
    chk("cv_X", cv_cnt - cv_base, 0);

    mark();
    send_byte(8'h42, 1'b1);
    chk("cmd_B", command, 16'hAA55);
    chk("lt_B", link_timeout, 1'b0);
    chk("cv_B", cv_cnt - cv_base, 1);

    @(posedge clk) rx = 1'b0;
    repeat (10) @(posedge clk);
    rx = 1'b0;
    repeat (10) @(posedge clk);
    rx = 1'b1;
    repeat (10) @(posedge clk);
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("cmd_mid_rst", command, 16'h0055);
    chk("cv_mid_rst", cmd_valid, 1'b0);
    chk("lt_mid_rst", link_timeout, 1'b0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    mark();
    chk("cmd_after_abort", command, 16'h0055);
    send_byte(8'h52, 1'b1);
    chk("cmd_R", command, 16'hEE55);
    chk("cv_R", cv_cnt - cv_base, 1);
    chk("fe_R", fe_cnt - fe_base, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
